// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types, the axis-length helper and standard mode presets for video_timing_gen.
package vtg_pkg;

  // Top-level sequencing: IDLE until the first enabled edge, then RUN.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vtg_state_e;

  // Standard modes for which preset timing sets are available.
  typedef enum logic [1:0] {
    MODE_640X480_60,
    MODE_800X600_60,
    MODE_1024X768_60
  } vtg_mode_e;

  // One axis worth of timing: lengths in pixels (h) or lines (v), plus the sync polarity.
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
    logic        pol;
  } vtg_axis_t;

  // Total length of one axis (H_TOTAL or V_TOTAL) from its four segments.
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Horizontal preset for a standard mode.
  function automatic vtg_axis_t h_preset(input vtg_mode_e mode);
    case (mode)
      MODE_640X480_60:  h_preset = '{16'd640,  16'd16, 16'd96,  16'd48,  1'b0};
      MODE_1024X768_60: h_preset = '{16'd1024, 16'd24, 16'd136, 16'd160, 1'b0};
      default:          h_preset = '{16'd800,  16'd40, 16'd128, 16'd88,  1'b1};
    endcase
  endfunction

  // Vertical preset for a standard mode.
  function automatic vtg_axis_t v_preset(input vtg_mode_e mode);
    case (mode)
      MODE_640X480_60:  v_preset = '{16'd480, 16'd10, 16'd2, 16'd33, 1'b0};
      MODE_1024X768_60: v_preset = '{16'd768, 16'd3,  16'd6, 16'd29, 1'b0};
      default:          v_preset = '{16'd600, 16'd1,  16'd4, 16'd23, 1'b1};
    endcase
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one timing axis (pixels or lines). Holds the position register, reports a
// carry when it wraps, and decodes the sync and active windows from the position that will be
// presented after the coming edge, so the parent can register those flags with zero skew.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int unsigned CW     = 12,
  parameter int unsigned ACTIVE = 800,
  parameter int unsigned FP     = 40,
  parameter int unsigned SYNC   = 128,
  parameter int unsigned BP     = 88,
  parameter int unsigned INIT   = 0
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] pos,
  output logic [CW-1:0] next_pos,
  output logic          carry,
  output logic          in_sync,
  output logic          in_active
);

  localparam int unsigned   TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  // Window bounds carry one extra bit: the end of the sync window may equal 2^CW.
  localparam logic [CW:0]   SYNC_LO = (CW+1)'(ACTIVE + FP);
  localparam logic [CW:0]   SYNC_HI = (CW+1)'(ACTIVE + FP + SYNC);
  localparam logic [CW:0]   ACT_HI  = (CW+1)'(ACTIVE);

  if (longint'(TOTAL) - 1 > (longint'(1) << CW) - 1) begin : g_width_check
    $error("vtg_axis_counter: CW=%0d cannot hold position %0d", CW, TOTAL - 1);
  end
  if (INIT > TOTAL - 1) begin : g_init_check
    $error("vtg_axis_counter: INIT=%0d outside 0..%0d", INIT, TOTAL - 1);
  end

  logic [CW:0] next_ext;

  // Next position: hold, increment, or wrap to 0 after the last position.
  always_comb begin
    // NOTE: next_pos gets a default before any branch so every path assigns it and no latch is inferred.
    next_pos = pos;
    if (step) begin
      next_pos = (pos == LAST) ? '0 : pos + CW'(1);
    end
  end

  assign carry     = step && (pos == LAST);
  assign next_ext  = {1'b0, next_pos};
  assign in_sync   = (next_ext >= SYNC_LO) && (next_ext < SYNC_HI);
  assign in_active = (next_ext < ACT_HI);

  // Position register, preloaded with INIT while reset is high.
  always_ff @(posedge pixel_clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (reset) begin
      pos <= CW'(INIT);
    end else begin
      pos <= next_pos;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator. All outputs are registered and
// describe the same pixel in the same cycle; sync and de are decoded from the next position.
// Optional feature macro: VTG_FETCH_AHEAD_EN adds fetch_h/fetch_v, the position displayed
// FETCH_LEAD enabled cycles later, for renderers with character-RAM/font-ROM latency.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned CW         = 12,
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter logic        H_POL      = 1'b1,
  parameter logic        V_POL      = 1'b1,
  parameter int unsigned FETCH_LEAD = 2
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] h_pos,
  output logic [CW-1:0] v_pos,
  output logic          line_start,
  output logic          frame_start
`ifdef VTG_FETCH_AHEAD_EN
  ,
  output logic [CW-1:0] fetch_h,
  output logic [CW-1:0] fetch_v
`endif
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);

  if (FETCH_LEAD < 1 || FETCH_LEAD > H_TOTAL - 1) begin : g_lead_check
    $error("video_timing_gen: FETCH_LEAD=%0d outside 1..%0d", FETCH_LEAD, H_TOTAL - 1);
  end

  vtg_state_e    state;
  logic          adv;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          h_carry;
  logic          h_in_sync;
  logic          h_in_active;
  logic          v_in_sync;
  logic          v_in_active;
  logic          unused_v_carry;
  logic          hs_d;
  logic          vs_d;
  logic          de_d;
  logic          ls_d;
  logic          fs_d;

  // The IDLE->RUN edge presents (0,0) without advancing; later enabled edges advance.
  assign adv = en && (state == RUN);

  vtg_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .INIT(0)
  ) u_h_axis (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .step      (adv),
    .pos       (h_pos),
    .next_pos  (h_next),
    .carry     (h_carry),
    .in_sync   (h_in_sync),
    .in_active (h_in_active)
  );

  vtg_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .INIT(0)
  ) u_v_axis (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .step      (h_carry),
    .pos       (v_pos),
    .next_pos  (v_next),
    .carry     (unused_v_carry),
    .in_sync   (v_in_sync),
    .in_active (v_in_active)
  );

`ifdef VTG_FETCH_AHEAD_EN
  logic          fetch_h_carry;
  logic [CW-1:0] unused_fetch_h_next;
  logic [CW-1:0] unused_fetch_v_next;
  logic          unused_fetch_v_carry;
  logic          unused_fetch_h_sync;
  logic          unused_fetch_h_active;
  logic          unused_fetch_v_sync;
  logic          unused_fetch_v_active;

  // Lead counter pair: starts FETCH_LEAD pixels ahead and advances under the same enable.
  vtg_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .INIT(FETCH_LEAD)
  ) u_fetch_h_axis (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .step      (adv),
    .pos       (fetch_h),
    .next_pos  (unused_fetch_h_next),
    .carry     (fetch_h_carry),
    .in_sync   (unused_fetch_h_sync),
    .in_active (unused_fetch_h_active)
  );

  vtg_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .INIT(0)
  ) u_fetch_v_axis (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .step      (fetch_h_carry),
    .pos       (fetch_v),
    .next_pos  (unused_fetch_v_next),
    .carry     (unused_fetch_v_carry),
    .in_sync   (unused_fetch_v_sync),
    .in_active (unused_fetch_v_active)
  );
`endif

  // Flags for the pixel that the coming edge will present.
  assign hs_d = h_in_sync ? H_POL : ~H_POL;
  assign vs_d = v_in_sync ? V_POL : ~V_POL;
  assign de_d = h_in_active && v_in_active;
  assign ls_d = (h_next == '0);
  assign fs_d = (h_next == '0) && (v_next == '0);

  // Timing FSM: on each enabled edge register the flags of the presented pixel; strobes
  // drop on any edge without en so they stay one cycle wide across stalls.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state       <= RUN;
            h_sync      <= hs_d;
            v_sync      <= vs_d;
            de          <= de_d;
            line_start  <= ls_d;
            frame_start <= fs_d;
          end
        end
        RUN: begin
          if (en) begin
            h_sync      <= hs_d;
            v_sync      <= vs_d;
            de          <= de_d;
            line_start  <= ls_d;
            frame_start <= fs_d;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of video_timing_gen. One instance uses the default
// 800x600 timing (line-level behaviour), a second a tiny 15x8 raster with inverted h_sync
// polarity and a 4-bit position width so whole frames fit in a short run.
module tb_video_timing_gen;

  logic       pixel_clk = 1'b0;
  logic       reset;
  logic       en;
  logic       en_s;

  logic        h_sync, v_sync, de, line_start, frame_start;
  logic [11:0] h_pos, v_pos;
  logic        s_h_sync, s_v_sync, s_de, s_line_start, s_frame_start;
  logic [3:0]  s_h_pos, s_v_pos;
`ifdef VTG_FETCH_AHEAD_EN
  logic [11:0] fetch_h, fetch_v;
  logic [3:0]  s_fetch_h, s_fetch_v;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .en          (en),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .de          (de),
    .h_pos       (h_pos),
    .v_pos       (v_pos),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VTG_FETCH_AHEAD_EN
    ,
    .fetch_h     (fetch_h),
    .fetch_v     (fetch_v)
`endif
  );

  video_timing_gen #(
    .CW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b1), .FETCH_LEAD(3)
  ) dut_s (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .en          (en_s),
    .h_sync      (s_h_sync),
    .v_sync      (s_v_sync),
    .de          (s_de),
    .h_pos       (s_h_pos),
    .v_pos       (s_v_pos),
    .line_start  (s_line_start),
    .frame_start (s_frame_start)
`ifdef VTG_FETCH_AHEAD_EN
    ,
    .fetch_h     (s_fetch_h),
    .fetch_v     (s_fetch_v)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One edge of the default instance with the given enable; sample 1 ns after the edge.
  task automatic step_d(input logic e);
    en = e;
    @(posedge pixel_clk);
    #1;
  endtask

  // One edge of the small instance with the given enable.
  task automatic step_s(input logic e);
    en_s = e;
    @(posedge pixel_clk);
    #1;
  endtask

  // Small-raster expectations for pixel (h, v): H_TOTAL 15, sync 10..12 active-low,
  // V_TOTAL 8, v_sync lines 5..6 active-high, visible 8x4.
  task automatic check_small(input string tag, input int h, input int v);
    check({tag, "_h"},  s_h_pos, h);
    check({tag, "_v"},  s_v_pos, v);
    check({tag, "_de"}, s_de, (h < 8 && v < 4));
    check({tag, "_hs"}, s_h_sync, (h >= 10 && h < 13) ? 0 : 1);
    check({tag, "_vs"}, s_v_sync, (v >= 5 && v < 7));
`ifdef VTG_FETCH_AHEAD_EN
    begin
      int lh;
      int lv;
      lh = h + 3;
      lv = v;
      if (lh >= 15) begin
        lh = lh - 15;
        lv = (v + 1) % 8;
      end
      check({tag, "_fh"}, s_fetch_h, lh);
      check({tag, "_fv"}, s_fetch_v, lv);
    end
`endif
  endtask

  initial begin
    int   hs_cnt;
    int   fs_cnt;
    int   eh;
    int   ev;
    logic prev_vs;

    reset = 1'b1;
    en    = 1'b0;
    en_s  = 1'b0;
    #12;
    // Reset values on both instances.
    check("rst_h", h_pos, 0);
    check("rst_v", v_pos, 0);
    check("rst_hs", h_sync, 0);
    check("rst_vs", v_sync, 0);
    check("rst_de", de, 0);
    check("rst_ls", line_start, 0);
    check("rst_fs", frame_start, 0);
    check("s_rst_hs", s_h_sync, 1);
    check("s_rst_vs", s_v_sync, 0);
    check("s_rst_de", s_de, 0);
`ifdef VTG_FETCH_AHEAD_EN
    check("rst_fh", fetch_h, 2);
    check("rst_fv", fetch_v, 0);
`endif
    @(negedge pixel_clk);
    reset = 1'b0;

    // Disabled edges in IDLE change nothing.
    step_d(1'b0);
    step_d(1'b0);
    check("idle_de", de, 0);
    check("idle_ls", line_start, 0);
    check("idle_fs", frame_start, 0);
    check("idle_h", h_pos, 0);

    // First enabled edge presents (0,0) with both strobes.
    step_d(1'b1);
    check("first_h", h_pos, 0);
    check("first_v", v_pos, 0);
    check("first_de", de, 1);
    check("first_ls", line_start, 1);
    check("first_fs", frame_start, 1);
    check("first_hs", h_sync, 0);
    check("first_vs", v_sync, 0);

    // Line 0 with a 5-cycle stall at h_pos=799.
    hs_cnt = 0;
    for (int h = 1; h < 1056; h++) begin
      if (h == 800) begin
        for (int k = 0; k < 5; k++) begin
          step_d(1'b0);
          check("stall_h", h_pos, 799);
          check("stall_de", de, 1);
          check("stall_hs", h_sync, 0);
          check("stall_ls", line_start, 0);
        end
      end
      step_d(1'b1);
      check("l0_h", h_pos, h);
      check("l0_v", v_pos, 0);
      check("l0_de", de, (h < 800));
      check("l0_hs", h_sync, (h >= 840 && h < 968));
      check("l0_vs", v_sync, 0);
      check("l0_ls", line_start, 0);
      check("l0_fs", frame_start, 0);
`ifdef VTG_FETCH_AHEAD_EN
      check("l0_fh", fetch_h, (h + 2) % 1056);
      check("l0_fv", fetch_v, (h + 2 >= 1056));
`endif
      if (h_sync === 1'b1) hs_cnt++;
    end
    check("hs_width", hs_cnt, 128);

    // Line wrap: h 1055 -> 0, v 0 -> 1, line strobe only.
    step_d(1'b1);
    check("wrap_h", h_pos, 0);
    check("wrap_v", v_pos, 1);
    check("wrap_ls", line_start, 1);
    check("wrap_fs", frame_start, 0);
    check("wrap_de", de, 1);
    check("wrap_hs", h_sync, 0);

    // Stall on a strobed pixel: strobe drops, pixel holds, not re-strobed on resume.
    for (int k = 0; k < 2; k++) begin
      step_d(1'b0);
      check("sst_h", h_pos, 0);
      check("sst_v", v_pos, 1);
      check("sst_ls", line_start, 0);
    end
    step_d(1'b1);
    check("resume_h", h_pos, 1);
    check("resume_ls", line_start, 0);

    for (int h = 2; h <= 500; h++) step_d(1'b1);
    check("mid_h", h_pos, 500);
    check("mid_v", v_pos, 1);

    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1'b1;
    #1;
    check("arst_h", h_pos, 0);
    check("arst_v", v_pos, 0);
    check("arst_de", de, 0);
    check("arst_hs", h_sync, 0);
    check("arst_ls", line_start, 0);
    @(negedge pixel_clk);
    reset = 1'b0;
    step_d(1'b1);
    check("rerun_h", h_pos, 0);
    check("rerun_v", v_pos, 0);
    check("rerun_fs", frame_start, 1);
    check("rerun_ls", line_start, 1);
    check("rerun_de", de, 1);
    en = 1'b0;

    // Small raster: two full frames with stalls after a line strobe and a frame strobe.
    step_s(1'b1);
    check_small("s_first", 0, 0);
    check("s_first_ls", s_line_start, 1);
    check("s_first_fs", s_frame_start, 1);
    eh      = 0;
    ev      = 0;
    fs_cnt  = 0;
    prev_vs = s_v_sync;
    for (int c = 1; c <= 240; c++) begin
      if (c == 76 || c == 121) begin
        for (int k = 0; k < 2; k++) begin
          step_s(1'b0);
          check_small("s_stall", eh, ev);
          check("s_stall_ls", s_line_start, 0);
          check("s_stall_fs", s_frame_start, 0);
        end
      end
      step_s(1'b1);
      eh++;
      if (eh == 15) begin
        eh = 0;
        ev = (ev + 1) % 8;
      end
      check_small("s_run", eh, ev);
      check("s_run_ls", s_line_start, (eh == 0));
      check("s_run_fs", s_frame_start, (eh == 0 && ev == 0));
      if (s_frame_start === 1'b1) fs_cnt++;
      if (s_v_sync !== prev_vs) check("s_vs_edge_h", s_h_pos, 0);
      prev_vs = s_v_sync;
    end
    check("s_frames", fs_cnt, 2);

    // Mid-frame asynchronous reset at (5,3).
    for (int c = 0; c < 50; c++) step_s(1'b1);
    check_small("s_mid", 5, 3);
    #2 reset = 1'b1;
    #1;
    check("s_arst_h", s_h_pos, 0);
    check("s_arst_v", s_v_pos, 0);
    check("s_arst_hs", s_h_sync, 1);
    check("s_arst_de", s_de, 0);
    check("s_arst_fs", s_frame_start, 0);
    @(negedge pixel_clk);
    reset = 1'b0;
    step_s(1'b1);
    check_small("s_rerun", 0, 0);
    check("s_rerun_fs", s_frame_start, 1);
    check("s_rerun_ls", s_line_start, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 timing controller. Generates pixel-coherent h_sync, v_sync, display-enable and position outputs, plus line/frame start strobes.
- Position counter width, all porch/sync/active lengths and both polarities are parameters.
- Sits between the pixel clock domain and the text-mode renderer (character/font fetch, pixel serialiser). The renderer uses de and the strobes instead of decoding positions itself.

Parameters:
- CW, 12, width of h_pos/v_pos; elaboration error if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_POL, 1'b1, asserted level of h_sync
- V_POL, 1'b1, asserted level of v_sync
- FETCH_LEAD, 2, pixels of lead on the fetch outputs (used only with the optional feature; range 1..H_TOTAL-1)

Ports:
- pixel_clk  in  1  pixel clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  advance enable; low freezes timing
- h_sync  out  1  horizontal sync at H_POL level while asserted
- v_sync  out  1  vertical sync at V_POL level while asserted
- de  out  1  display enable; high when h_pos<H_ACTIVE and v_pos<V_ACTIVE
- h_pos  out  CW  current pixel column, 0..H_TOTAL-1
- v_pos  out  CW  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle strobe while presenting h_pos=0
- frame_start  out  1  one-cycle strobe while presenting h_pos=0, v_pos=0
- fetch_h  out  CW  lead column (optional feature only)
- fetch_v  out  CW  lead line (optional feature only)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628)
- Clock and reset: one clock, pixel_clk. Reset is asynchronous, active-high.
- Reset values:
  - h_pos=0, v_pos=0
  - h_sync=~H_POL, v_sync=~V_POL
  - de=0, line_start=0, frame_start=0
  - state IDLE
- Two-state FSM:
  - IDLE -> RUN on the first rising edge with en=1 after reset deasserts. That edge presents pixel (0,0): de=1, line_start=1, frame_start=1.
  - RUN: each rising edge with en=1 advances to the next pixel.
  - Reset from any state, including mid-frame, returns to IDLE with the reset values above, asynchronously.
- Coherence: all outputs are registered and describe the same pixel in the same cycle.
  - Sync and de are computed from the next position, so they have zero skew relative to h_pos/v_pos. The previous generation's one-cycle sync lag is removed.
- Horizontal counter:
  - h_pos increments by 1.
  - At H_TOTAL-1 it wraps to 0, and v_pos increments.
  - At v_pos=V_TOTAL-1 with h_pos=H_TOTAL-1, both wrap to 0 and frame_start fires.
- h_sync is asserted for H_ACTIVE+H_FP <= h_pos < H_ACTIVE+H_FP+H_SYNC (default 840..967).
- v_sync is asserted for V_ACTIVE+V_FP <= v_pos < V_ACTIVE+V_FP+V_SYNC (default 601..604).
  - v_sync transitions only on cycles where h_pos=0.
- en=0 in RUN:
  - h_pos, v_pos, h_sync, v_sync and de hold.
  - line_start and frame_start drop to 0, so each strobe is exactly one cycle wide even across a stall.
  - On en re-assertion, advance resumes from the held pixel. The held pixel is not re-strobed.
- en=0 in IDLE: remain in IDLE.
- Arithmetic: comparisons are unsigned at CW bits; there are no 32-bit positions.

Optional Feature:
- Macro: VTG_FETCH_AHEAD_EN.
- Defined:
  - fetch_h/fetch_v give the position displayed FETCH_LEAD enabled cycles later. They wrap across line and frame boundaries with the same rules as h_pos/v_pos.
  - Implemented as a second counter pair preloaded at reset to (FETCH_LEAD, 0) and advanced under the same en.
  - Hides character-RAM and font-ROM latency in the renderer.
- Not defined: the fetch ports and the lead counters are absent. Port list ends at frame_start.

Decomposition:
- Shared package vtg_pkg:
  - localparam functions for H_TOTAL and V_TOTAL
  - preset constant sets: 640x480@60, 800x600@60, 1024x768@60
  - state enum (IDLE, RUN)
- One natural sub-module, vtg_axis_counter: a single-axis counter with wrap output and a sync/active window decode.
  - Instantiated for the h axis and the v axis.
  - Instantiated again for the fetch pair under VTG_FETCH_AHEAD_EN.

Test Plan:
- Reset, then en=1 for one edge -> h_pos=0, v_pos=0, de=1, line_start=1, frame_start=1, h_sync=0, v_sync=0.
- Run to h_pos=1055 -> next edge gives h_pos=0, v_pos+1, line_start=1. h_sync high exactly for h_pos 840..967 (128 cycles), aligned with h_pos. de=0 from h_pos=800.
- Run a full frame (1056*628=663168 enabled cycles) -> frame_start exactly once per frame, at (0,0). v_sync high for lines 601..604, changing only at h_pos=0.
- Drop en for 5 cycles at h_pos=799 -> all outputs hold. Strobes are 0 during the stall. Advance resumes at h_pos=800.
- Assert reset at (h=500, v=300) asynchronously mid-cycle -> outputs return to reset values before the next edge. The first enabled edge after release re-presents (0,0) with frame_start=1.
- With VTG_FETCH_AHEAD_EN and FETCH_LEAD=2 -> fetch_h=h_pos+2 mod 1056. At h_pos=1054, fetch=(0, v_pos+1). At h_pos=1055, v_pos=627, fetch=(1, 0).
